// File: rtl/cpu_mem_pkg.sv
// Shared constants and FSM state type for the CPU memory responder.
package cpu_mem_pkg;
  localparam int DATA_W  = 8;
  localparam int ADDR_W  = 4;
  localparam int DEPTH   = 2 ** ADDR_W;
  localparam int LEN_MAX = DEPTH;

  typedef enum logic [1:0] {
    HOLD,
    LOAD,
    DONE,
    RUN
  } state_t;
endpackage

// File: rtl/cpu_mem_responder_if.sv
// CPU memory bus plus program-loader byte stream.
interface cpu_mem_responder_if
  import cpu_mem_pkg::*;
#(
  parameter int DW = DATA_W,
  parameter int AW = ADDR_W
);
  logic          read;
  logic          write;
  logic [AW-1:0] address;
  logic [DW-1:0] memoryIn;
  logic [DW-1:0] memoryOut;
  logic          load_start;
  logic [AW:0]   load_len;
  logic          load_valid;
  logic [DW-1:0] load_data;
  logic          load_ready;

  modport master (
    output read, write, address, memoryIn,
    output load_start, load_len,
    output load_valid, load_data,
    input  memoryOut, load_ready
  );

  modport slave (
    input  read, write, address, memoryIn,
    input  load_start, load_len,
    input  load_valid, load_data,
    output memoryOut, load_ready
  );
endinterface

// File: rtl/mem_array.sv
// Register-file RAM: one write port, two combinational read ports.
module mem_array
  import cpu_mem_pkg::*;
#(
  parameter int DW = DATA_W,
  parameter int AW = ADDR_W
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr_a,
  output logic [DW-1:0] rdata_a,
  input  logic [AW-1:0] raddr_b,
  output logic [DW-1:0] rdata_b
);
  localparam int N = 2 ** AW;

  logic [DW-1:0] mem [N];

  // Clear wins over a same-cycle write.
  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < N; i++)
        mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];
endmodule

// File: rtl/cpu_mem_responder.sv
// CPU-side RAM with a program loader that holds the CPU in clear.
module cpu_mem_responder
  import cpu_mem_pkg::*;
#(
  parameter int DW       = DATA_W,
  parameter int AW       = ADDR_W,
  parameter int AUTO_RUN = 0
) (
  input  logic                clk,
  input  logic                clr,
  cpu_mem_responder_if.slave  bus,
  output logic                load_done,
  output logic                cpu_hold,
  input  logic [AW-1:0]       dbg_addr,
  output logic [DW-1:0]       dbg_data,
  output logic [7:0]          write_count,
  output logic [7:0]          read_count
);
  localparam logic [AW:0] FULL = (AW+1)'(2 ** AW);
  localparam logic [AW:0] ONE  = (AW+1)'(1);

  state_t        state;
  logic [AW-1:0] ptr;
  logic [AW:0]   len;
  logic          ready_q;
  logic [AW:0]   len_in;
  logic          load_acc;
  logic          cpu_we;
  logic          last;
  logic          we;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;

  assign len_in = (bus.load_len == '0 || bus.load_len > FULL)
                ? FULL : bus.load_len;

  assign load_acc = (state == LOAD) && bus.load_valid && ready_q;
  assign cpu_we   = (state == RUN) && bus.write;
  assign last     = ((AW+1)'(ptr) + ONE) == len;

  assign we    = load_acc | cpu_we;
  assign waddr = load_acc ? ptr : bus.address;
  assign wdata = load_acc ? bus.load_data : bus.memoryIn;

  assign bus.load_ready = ready_q;

  mem_array #(.DW(DW), .AW(AW)) u_mem (
    .clk     (clk),
    .clr     (clr),
    .we      (we),
    .waddr   (waddr),
    .wdata   (wdata),
    .raddr_a (bus.address),
    .rdata_a (bus.memoryOut),
    .raddr_b (dbg_addr),
    .rdata_b (dbg_data)
  );

  always_ff @(posedge clk) begin
    if (clr) begin
      state       <= (AUTO_RUN != 0) ? RUN : HOLD;
      cpu_hold    <= (AUTO_RUN == 0);
      ready_q     <= 1'b0;
      load_done   <= 1'b0;
      ptr         <= '0;
      len         <= FULL;
      write_count <= '0;
      read_count  <= '0;
    end else begin
      load_done <= 1'b0;
      unique case (state)
        HOLD: begin
          if (bus.load_start) begin
            state   <= LOAD;
            ready_q <= 1'b1;
            len     <= len_in;
            ptr     <= '0;
          end
        end
        LOAD: begin
          // ptr parks on the last address instead of wrapping
          if (load_acc) begin
            if (last) begin
              state     <= DONE;
              ready_q   <= 1'b0;
              load_done <= 1'b1;
            end else begin
              ptr <= ptr + 1'b1;
            end
          end
        end
        DONE: begin
          state    <= RUN;
          cpu_hold <= 1'b0;
        end
        RUN: begin
          if (bus.load_start) begin
            state       <= LOAD;
            cpu_hold    <= 1'b1;
            ready_q     <= 1'b1;
            len         <= len_in;
            ptr         <= '0;
            write_count <= '0;
            read_count  <= '0;
          end else begin
            if (bus.write && write_count != 8'hFF)
              write_count <= write_count + 8'd1;
            if (bus.read && read_count != 8'hFF)
              read_count <= read_count + 8'd1;
          end
        end
        default: state <= HOLD;
      endcase
    end
  end
endmodule

// File: tb/tb_cpu_mem_responder.sv
// Randomised and directed bench for cpu_mem_responder against a
// behavioural model of the loader/RAM.
module tb_cpu_mem_responder;
  import cpu_mem_pkg::*;

  logic       clk = 1'b0;
  logic       clr;
  logic       load_done;
  logic       cpu_hold;
  logic [3:0] dbg_addr;
  logic [7:0] dbg_data;
  logic [7:0] write_count;
  logic [7:0] read_count;

  cpu_mem_responder_if bus ();

  cpu_mem_responder dut (
    .clk         (clk),
    .clr         (clr),
    .bus         (bus.slave),
    .load_done   (load_done),
    .cpu_hold    (cpu_hold),
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data),
    .write_count (write_count),
    .read_count  (read_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // stimulus for the next edge
  logic       rst, rd, wr, ls, lv;
  logic [3:0] addr, da;
  logic [7:0] mi, ld;
  logic [4:0] ll;

  // behavioural model
  localparam int P_HOLD = 0;
  localparam int P_LOAD = 1;
  localparam int P_DONE = 2;
  localparam int P_RUN  = 3;
  logic [7:0] m_mem [16];
  int m_phase, m_len, m_got, m_wc, m_rc;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle();
    rst = 0; rd = 0; wr = 0; ls = 0; lv = 0;
    addr = 0; da = 0; mi = 0; ld = 0; ll = 0;
  endtask

  task automatic start_load();
    m_phase = P_LOAD;
    m_len   = (ll == 0 || ll > 16) ? 16 : int'(ll);
    m_got   = 0;
  endtask

  task automatic model_edge();
    if (rst) begin
      foreach (m_mem[i]) m_mem[i] = 8'h00;
      m_phase = P_HOLD;
      m_wc = 0; m_rc = 0; m_got = 0; m_len = 16;
    end else if (m_phase == P_HOLD) begin
      if (ls) start_load();
    end else if (m_phase == P_LOAD) begin
      if (lv) begin
        m_mem[m_got] = ld;
        m_got++;
        if (m_got == m_len) m_phase = P_DONE;
      end
    end else if (m_phase == P_DONE) begin
      m_phase = P_RUN;
    end else begin
      if (wr) m_mem[addr] = mi;
      if (ls) begin
        start_load();
        m_wc = 0; m_rc = 0;
      end else begin
        if (wr && m_wc < 255) m_wc++;
        if (rd && m_rc < 255) m_rc++;
      end
    end
  endtask

  task automatic compare_all();
    chk("memoryOut", bus.memoryOut, m_mem[addr]);
    chk("dbg_data", dbg_data, m_mem[da]);
    chk("cpu_hold", cpu_hold, m_phase != P_RUN);
    chk("load_ready", bus.load_ready, m_phase == P_LOAD);
    chk("load_done", load_done, m_phase == P_DONE);
    chk("write_count", write_count, m_wc);
    chk("read_count", read_count, m_rc);
  endtask

  task automatic step();
    clr            = rst;
    bus.read       = rd;
    bus.write      = wr;
    bus.address    = addr;
    bus.memoryIn   = mi;
    bus.load_start = ls;
    bus.load_len   = ll;
    bus.load_valid = lv;
    bus.load_data  = ld;
    dbg_addr       = da;
    model_edge();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic sweep();
    idle();
    for (int i = 0; i < 16; i++) begin
      da = 4'(i);
      addr = 4'(15 - i);
      step();
    end
  endtask

  logic [7:0] prog [8];
  int done_seen;

  initial begin
    prog[0] = 8'h77; prog[1] = 8'h54; prog[2] = 8'h54; prog[3] = 8'h00;
    prog[4] = 8'h00; prog[5] = 8'h00; prog[6] = 8'h02; prog[7] = 8'h06;

    idle(); rst = 1;
    step(); step();
    idle();
    chk("reset_hold", cpu_hold, 1);

    // CPU writes ignored in HOLD
    wr = 1; addr = 2; mi = 8'h33; rd = 1;
    step(); step();

    // 8-byte program, valid every cycle, CPU write during LOAD
    idle(); ls = 1; ll = 8;
    step();
    for (int i = 0; i < 8; i++) begin
      idle(); lv = 1; ld = prog[i];
      wr = 1; addr = 2; mi = 8'hEE;
      step();
    end
    idle(); step(); step();
    sweep();

    // RUN: write then reads
    idle(); wr = 1; addr = 4; mi = 8'hA5;
    step();
    idle(); addr = 4;
    step();
    chk("run_rdback", bus.memoryOut, 8'hA5);
    rd = 1; step(); step(); step();
    chk("read3", read_count, 8'd3);

    // gapped load of 3 bytes
    idle(); ls = 1; ll = 3;
    step();
    done_seen = 0;
    for (int i = 0; i < 10; i++) begin
      idle(); lv = i[0] ? 1'b0 : 1'b1; ld = 8'(8'h10 + i);
      step();
      if (load_done) done_seen++;
    end
    chk("gap_done_once", done_seen, 1);
    sweep();

    // len=0 means 16; reset after 5 bytes
    idle(); ls = 1; ll = 0;
    step();
    for (int i = 0; i < 5; i++) begin
      idle(); lv = 1; ld = 8'($urandom); step();
    end
    idle(); rst = 1; step();
    sweep();

    // full 16-byte load with len=0
    idle(); ls = 1; ll = 0;
    step();
    done_seen = 0;
    for (int i = 0; i < 20; i++) begin
      idle(); lv = 1; ld = 8'(8'hC0 + i);
      step();
      if (load_done) done_seen++;
    end
    chk("len16_done_once", done_seen, 1);
    sweep();

    // write counter saturation
    for (int i = 0; i < 300; i++) begin
      idle(); wr = 1; rd = i[0];
      addr = 4'($urandom); mi = 8'($urandom);
      step();
    end
    chk("wc_sat", write_count, 8'd255);
    idle(); ls = 1; ll = 2; wr = 1; addr = 9; mi = 8'h5A;
    step();
    chk("wc_cleared", write_count, 8'd0);
    chk("hold_rises", cpu_hold, 1);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      rst  = ($urandom_range(0, 299) == 0);
      ls   = ($urandom_range(0, 39) == 0);
      ll   = 5'($urandom);
      lv   = 1'($urandom);
      ld   = 8'($urandom);
      rd   = 1'($urandom);
      wr   = 1'($urandom);
      addr = 4'($urandom);
      mi   = 8'($urandom);
      da   = 4'($urandom);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cpu_mem_responder.md
Name: cpu_mem_responder

Overview:
- Memory-side responder for the CPU bus (read, write, address, memoryIn, memoryOut): a synthesizable 16 x 8 RAM that replaces the behavioural bench memory.
- Adds a program-loader front end. A byte-stream valid/ready port fills RAM from address 0 while the block holds the CPU in clear (cpu_hold), then releases it.
- Sits between the CPU and the system/bench load source. cpu_hold drives the CPU clr input.

Parameters:
- DATA_W, 8, data width of memory words and bus.
- ADDR_W, 4, address width; DEPTH = 2**ADDR_W = 16.
- AUTO_RUN, 0, if 1, after reset go straight to RUN with zeroed RAM and cpu_hold = 0; no load required.

Ports:
- clk  in  1  system clock, all state on rising edge
- clr  in  1  reset, synchronous, active-high
- read  in  1  CPU read strobe (counted only; reads are combinational)
- write  in  1  CPU write strobe
- address  in  ADDR_W  CPU address
- memoryIn  in  DATA_W  write data from CPU
- memoryOut  out  DATA_W  read data to CPU, mem[address]
- load_start  in  1  pulse: begin load session
- load_len  in  ADDR_W+1  bytes to load; 0 or >16 treated as 16
- load_valid  in  1  load byte valid
- load_data  in  DATA_W  load byte
- load_ready  out  1  loader accepts byte
- load_done  out  1  one-cycle pulse when load completes
- cpu_hold  out  1  hold CPU in clear (connect to CPU clr)
- dbg_addr  in  ADDR_W  debug read address
- dbg_data  out  DATA_W  mem[dbg_addr], combinational
- write_count  out  8  CPU writes accepted in RUN, saturating at 255
- read_count  out  8  cycles with read=1 in RUN, saturating at 255

Behaviour:
- Reset (clr=1 at edge): all 16 words = 0; state = HOLD (RUN if AUTO_RUN); cpu_hold = 1 (0 if AUTO_RUN); load_ready = 0; load_done = 0; counters = 0; ptr = 0. Reset mid-load discards the partial load and returns to HOLD.
- memoryOut = mem[address] and dbg_data = mem[dbg_addr]: zero-latency combinational reads in every state. A write becomes visible the cycle after its edge.
- States:
  - HOLD: cpu_hold=1, load_ready=0. load_start → LOAD; latch len (clamped); ptr=0.
  - LOAD: cpu_hold=1, load_ready=1. On valid&&ready: mem[ptr]<=load_data, ptr++. When the accepted byte is the len-th → DONE. load_start is ignored here.
  - DONE: one cycle. load_done=1, cpu_hold=1, load_ready=0 → RUN.
  - RUN: cpu_hold=0. write=1 at edge: mem[address]<=memoryIn, write_count++ (sat). read=1: read_count++ (sat). load_start → LOAD; counters cleared; ptr=0.
- All outputs except memoryOut/dbg_data are registered. cpu_hold rises the cycle after load_start is sampled in RUN. A CPU write sampled on that same edge still commits.
- CPU write/read strobes in HOLD, LOAD and DONE are ignored and not counted.
- read and write both high in RUN: write commits and both counters increment.
- load_valid with load_ready=0 is ignored; the source must hold the data.
- ptr does not wrap. len=16 writes addresses 0..15 and stops.

Decomposition:
- Package cpu_mem_pkg: DATA_W/ADDR_W/DEPTH constants; state enum {HOLD, LOAD, DONE, RUN}; LEN_MAX=16.
- Sub-module mem_array: DEPTH x DATA_W storage with two combinational read ports, one write port and synchronous clear on clr.
- The top level holds the FSM, the write-port mux (loader vs CPU) and the counters.

Test Plan:
- Reset then load_start with len=8 and bytes 0x77,0x54,0x54,0x00,0x00,0x00,0x02,0x06, valid every cycle → load_ready high 8 cycles; load_done pulses 1 cycle after the 8th byte; cpu_hold falls the cycle after load_done; dbg_data at addresses 0..7 matches; addresses 8..15 = 0x00.
- Load with gaps: load_valid toggling 1/0, len=3 → only 3 bytes written; ptr holds during gaps; load_done exactly once.
- RUN: write=1, address=4, memoryIn=0xA5 → memoryOut=0xA5 the next cycle at address 4; write_count=1. read high 3 cycles → read_count=3.
- write=1 at address 2 while in HOLD or LOAD → mem[2] unchanged; write_count stays 0.
- load_len=0 → 16 bytes accepted, ptr stops at 15, load_done once. clr asserted after 5 of 16 bytes → all memory 0x00, state HOLD, cpu_hold=1, load_ready=0.
- 300 writes in RUN → write_count saturates at 255. A new load_start clears both counters to 0 and raises cpu_hold the next cycle.
